// File: rtl/pong_pkg.sv
// Shared definitions for the Pong round sequencer: state encoding,
// ball-pace reload codes and score width.
package pong_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Reload select codes for the external ball-pace down-counter
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_MED  = 2'b10;
  localparam logic [1:0] SPD_FAST = 2'b00;

  // One speed step up, saturating at the fastest pace
  function automatic logic [1:0] next_speed(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      SPD_SLOW: nxt = SPD_MED;
      SPD_MED:  nxt = SPD_FAST;
      default:  nxt = SPD_FAST;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/round_timer.sv
// 4-bit loadable down-counter paced by the slow tick. A load always wins
// over a coincident tick, and the count saturates at zero.
module round_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic [3:0] value,
  output logic       zero
);

  // Load has priority; otherwise count down on tick while above zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (tick && (value != 4'd0)) begin
      value <= value - 4'd1;
    end
  end

  assign zero = (value == 4'd0);

endmodule

// File: rtl/pong_round_ctrl.sv
// Pong round sequencer: serve countdown, rally with speed-up, point hold,
// scoring and game over. Timing comes from the external slow tick.
// Build option: define PONG_AUTO_SERVE_EN to serve automatically as soon
// as the serve countdown expires; otherwise the serving side's button is
// required once the countdown has reached zero.
module pong_round_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 3,
  parameter int POINT_TICKS = 10,
  parameter int RALLY_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                miss_l,
  input  logic                miss_r,
  input  logic                paddle_hit,
  input  logic                serve_l,
  input  logic                serve_r,
  output logic [2:0]          state,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                serve_side,
  output logic                ball_release,
  output logic [1:0]          speed_sel,
  output logic [3:0]          countdown,
  output logic                game_over
);

  localparam int RW = (RALLY_STEP < 2) ? 1 : $clog2(RALLY_STEP + 1);

  localparam logic [3:0]         SERVE_V = 4'(SERVE_TICKS);
  localparam logic [3:0]         POINT_V = 4'(POINT_TICKS);
  localparam logic [SCORE_W-1:0] WIN_V   = SCORE_W'(WIN_SCORE);
  localparam logic [RW:0]        STEP_V  = (RW + 1)'(RALLY_STEP);

  state_t              state_q, state_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d;
  logic [SCORE_W-1:0]  score_r_q, score_r_d;
  logic                side_q, side_d;
  logic                release_q, release_d;
  logic [1:0]          speed_q, speed_d;
  logic [RW-1:0]       rally_q, rally_d;
  logic                over_q;

  logic                tmr_load;
  logic [3:0]          tmr_val;
  logic [3:0]          tmr_value;
  logic                tmr_zero;
  logic                serve_ok;
  logic [SCORE_W-1:0]  score_l_inc;
  logic [SCORE_W-1:0]  score_r_inc;
  logic [RW:0]         rally_inc;

  round_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

`ifdef PONG_AUTO_SERVE_EN
  logic unused_serve_buttons;
  assign unused_serve_buttons = serve_l | serve_r;
  assign serve_ok = 1'b1;
`else
  assign serve_ok = side_q ? serve_r : serve_l;
`endif

  assign score_l_inc = score_l_q + 1'b1;
  assign score_r_inc = score_r_q + 1'b1;
  assign rally_inc   = {1'b0, rally_q} + 1'b1;

  // State and round-data registers; reset abandons any game in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      side_q    <= 1'b0;
      release_q <= 1'b0;
      speed_q   <= SPD_SLOW;
      rally_q   <= '0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      side_q    <= side_d;
      release_q <= release_d;
      speed_q   <= speed_d;
      rally_q   <= rally_d;
      over_q    <= (state_d == ST_OVER);
    end
  end

  // Next-state, scoring, rally/speed and timer-load decisions
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    side_d    = side_q;
    release_d = 1'b0;
    speed_d   = speed_q;
    rally_d   = rally_q;
    tmr_load  = 1'b0;
    tmr_val   = SERVE_V;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          side_d    = 1'b0;
          speed_d   = SPD_SLOW;
          rally_d   = '0;
          tmr_load  = 1'b1;
          tmr_val   = SERVE_V;
          state_d   = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (tmr_zero && serve_ok) begin
          release_d = 1'b1;
          state_d   = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (miss_l || miss_r) begin
          speed_d  = SPD_SLOW;
          rally_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = POINT_V;
          state_d  = ST_POINT;
          if (miss_l && !miss_r) begin
            score_r_d = score_r_inc;
            side_d    = 1'b0;
            if (score_r_inc == WIN_V) begin
              state_d = ST_OVER;
            end
          end else if (miss_r && !miss_l) begin
            score_l_d = score_l_inc;
            side_d    = 1'b1;
            if (score_l_inc == WIN_V) begin
              state_d = ST_OVER;
            end
          end
        end else if (paddle_hit) begin
          if (rally_inc == STEP_V) begin
            rally_d = '0;
            speed_d = next_speed(speed_q);
          end else begin
            rally_d = rally_inc[RW-1:0];
          end
        end
      end

      ST_POINT: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = SERVE_V;
          state_d  = ST_SERVE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state        = state_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign serve_side   = side_q;
  assign ball_release = release_q;
  assign speed_sel    = speed_q;
  assign game_over    = over_q;
  assign countdown    = ((state_q == ST_SERVE) || (state_q == ST_POINT)) ? tmr_value : 4'd0;

endmodule
